mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/access_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IF_ACC = 2'b01,
        ST_DM_ACC = 2'b10
    } arb_state_e;

endpackage

// File: rtl/access_timer.sv
// 8-bit clear/enable access timer; expired_o flags the cycle whose increment reaches TIMEOUT.
module access_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only meaningful on a cycle that actually counts (no mem_ready).
    assign expired_o = en_i && (count_q == LIMIT - 8'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-memory requests onto a single external memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic in_acc;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    assign in_acc    = (state_q != ST_IDLE);
    assign timer_clr = !in_acc;
    assign timer_en  = in_acc && !mem_ready;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i    (clock),
        .rst_i    (rst),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        case (state_q)
            // A requester whose done is high this cycle is already served.
            ST_IDLE: begin
                if (dm_req && !dm_done_q) begin
                    state_d     = ST_DM_ACC;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_req && !if_done_q) begin
                    state_d     = ST_IF_ACC;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_IF_ACC, ST_DM_ACC: begin
                if (mem_ready || timer_expired) begin
                    state_d  = ST_IDLE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (state_q == ST_IF_ACC) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    end
                    if (timer_expired) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    assign stall     = (if_req & ~if_done_q) | (dm_req & ~dm_done_q);
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// transaction-schedule reference model.
module tb_mem_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clock = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;
    logic          err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall    (stall),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        checks++;
        if ({if_done, dm_done, mem_en, mem_we, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {if_done, dm_done, mem_en, mem_we, err});
        end
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", {if_rdata, dm_rdata, mem_addr, mem_wdata});
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        if_req  = 1'b1;
        if_addr = 16'h0004;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_n: got %b expected 1", stall); end
        step();
        checks++;
        if ({mem_en, mem_we, if_done, mem_addr} !== {3'b100, 16'h0004}) begin
            errors++;
            $display("FAIL fetch_acc: got en/we/done/addr %b %h expected 100 0004", {mem_en, mem_we, if_done}, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h1234;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_n1: got %b expected 1", stall); end
        step();
        mem_ready = 1'b0;
        mem_rdata = 16'hDEAD;
        checks++;
        if ({if_done, mem_en, if_rdata} !== {2'b10, 16'h1234}) begin
            errors++;
            $display("FAIL fetch_done: got done/en %b rdata %h expected 10 1234", {if_done, mem_en}, if_rdata);
        end
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_n2: got %b expected 0", stall); end
        if_req = 1'b0;
        step();
        checks++;
        if ({if_done, mem_en, if_rdata} !== {2'b00, 16'h1234}) begin
            errors++;
            $display("FAIL fetch_hold: got done/en %b rdata %h expected 00 1234", {if_done, mem_en}, if_rdata);
        end
    endtask

    task automatic test_simultaneous();
        if_req  = 1'b1;
        if_addr = 16'h0100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h0020;
        step();
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'h0020}) begin
            errors++;
            $display("FAIL simul_dm_first: got en/we %b addr %h expected 10 0020", {mem_en, mem_we}, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hA5A5;
        step();
        checks++;
        if ({dm_done, if_done, mem_en, dm_rdata} !== {3'b100, 16'hA5A5}) begin
            errors++;
            $display("FAIL simul_dm_done: got dmd/ifd/en %b rdata %h expected 100 a5a5", {dm_done, if_done, mem_en}, dm_rdata);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL simul_stall_mid: got %b expected 1", stall); end
        step();
        dm_req = 1'b0;
        checks++;
        if ({mem_en, mem_we, dm_done, mem_addr} !== {3'b100, 16'h0100}) begin
            errors++;
            $display("FAIL simul_if_second: got en/we/dmd %b addr %h expected 100 0100", {mem_en, mem_we, dm_done}, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        step();
        mem_ready = 1'b0;
        checks++;
        if ({if_done, dm_done, if_rdata} !== {2'b10, 16'h5A5A}) begin
            errors++;
            $display("FAIL simul_if_done: got ifd/dmd %b rdata %h expected 10 5a5a", {if_done, dm_done}, if_rdata);
        end
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL simul_stall_end: got %b expected 0", stall); end
        if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        int we_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 16'h0010;
        dm_wdata = 16'hBEEF;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (mem_we === 1'b1) we_cnt++;
            if (c == 1) begin
                checks++;
                if ({mem_en, mem_addr, mem_wdata} !== {1'b1, 16'h0010, 16'hBEEF}) begin
                    errors++;
                    $display("FAIL store_acc: got en %b addr %h wdata %h expected 1 0010 beef", mem_en, mem_addr, mem_wdata);
                end
            end
            if (dm_done === 1'b1) begin
                done_cnt++;
                done_at = c;
                checks++;
                if (dm_rdata !== 16'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0000", dm_rdata); end
            end
            mem_ready = (c == 4);
            mem_rdata = (c == 4) ? 16'h5555 : 16'h0;
            if (c >= 6) begin
                dm_req = 1'b0;
                dm_we  = 1'b0;
            end
        end
        checks++;
        if (we_cnt != 4) begin errors++; $display("FAIL store_we_cycles: got %0d expected 4", we_cnt); end
        checks++;
        if (done_cnt != 1 || done_at != 5) begin
            errors++;
            $display("FAIL store_done: got count %0d at %0d expected 1 at 5", done_cnt, done_at);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", err); end
    endtask

    task automatic test_timeout();
        int en_cnt = 0;
        int done_at = -1;
        if_req    = 1'b1;
        if_addr   = 16'h0040;
        mem_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (mem_en === 1'b1) en_cnt++;
            if (if_done === 1'b1) begin
                done_at = c;
                checks++;
                if ({err, if_rdata} !== {1'b1, 16'h0}) begin
                    errors++;
                    $display("FAIL timeout_done: got err %b rdata %h expected 1 0000", err, if_rdata);
                end
            end
            if (done_at > 0 && c > done_at) if_req = 1'b0;
        end
        checks++;
        if (done_at != 5 || en_cnt != 4) begin
            errors++;
            $display("FAIL timeout_timing: got done at %0d en cycles %0d expected 5 and 4", done_at, en_cnt);
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", err); end
    endtask

    task automatic test_reset_mid();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 16'h0030;
        step();
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_acc: got %b expected 1", mem_en); end
        step();
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'h7777;
        step();
        checks++;
        if ({mem_en, dm_done, err, mem_addr, dm_rdata} !== {3'b000, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL rstmid_clear: got en/done/err %b addr %h rdata %h expected 000 0 0", {mem_en, dm_done, err}, mem_addr, dm_rdata);
        end
        rst       = 1'b0;
        mem_ready = 1'b0;
        step();
        checks++;
        if ({mem_en, dm_done, mem_addr} !== {2'b10, 16'h0030}) begin
            errors++;
            $display("FAIL rstmid_reissue: got en/done %b addr %h expected 10 0030", {mem_en, dm_done}, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = 16'h1357;
        step();
        checks++;
        if ({dm_done, dm_rdata} !== {1'b1, 16'h1357}) begin
            errors++;
            $display("FAIL rstmid_done: got done %b rdata %h expected 1 1357", dm_done, dm_rdata);
        end
        mem_ready = 1'b0;
        dm_req    = 1'b0;
        step();
    endtask

    task automatic test_held();
        for (int h = 3; h <= 4; h++) begin
            int en_cnt = 0;
            int dn_cnt = 0;
            int exp_n = (h == 3) ? 1 : 2;
            if_req    = 1'b1;
            if_addr   = 16'h0200;
            mem_ready = 1'b1;
            mem_rdata = 16'h2222;
            for (int c = 1; c <= 8; c++) begin
                step();
                if (mem_en === 1'b1) en_cnt++;
                if (if_done === 1'b1) dn_cnt++;
                if (c >= h) if_req = 1'b0;
            end
            checks++;
            if (en_cnt != exp_n || dn_cnt != exp_n) begin
                errors++;
                $display("FAIL held_h%0d: got accesses %0d dones %0d expected %0d", h, en_cnt, dn_cnt, exp_n);
            end
            mem_ready = 1'b0;
        end
    endtask

    // Reference: each transaction occupies min(delay+1, TO) port cycles, the data
    // request first, the next one starting the cycle after the previous done.
    task automatic test_random(input int iters);
        logic          exp_err;
        logic [DW-1:0] exp_if_rd;
        logic [DW-1:0] exp_dm_rd;
        rst = 1'b1;
        clear_inputs();
        step();
        rst       = 1'b0;
        exp_err   = 1'b0;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        for (int it = 0; it < iters; it++) begin
            int            mode = int'($urandom_range(0, 2));
            bit            has_if = (mode != 1);
            bit            has_dm = (mode != 0);
            int            n = 0;
            int            if_idx = 0;
            int            dm_idx = 0;
            int            s_a[2];
            int            d_a[2];
            int            dly_a[2];
            logic [AW-1:0] addr_a[2];
            logic [DW-1:0] wd_a[2];
            logic [DW-1:0] rd_a[2];
            logic          we_a[2];
            if (has_dm) begin
                dm_idx    = n;
                addr_a[n] = AW'($urandom);
                wd_a[n]   = DW'($urandom);
                we_a[n]   = 1'($urandom_range(0, 1));
                n++;
            end
            if (has_if) begin
                if_idx    = n;
                addr_a[n] = AW'($urandom);
                wd_a[n]   = '0;
                we_a[n]   = 1'b0;
                n++;
            end
            for (int k = 0; k < n; k++) begin
                dly_a[k] = int'($urandom_range(0, 5));
                rd_a[k]  = DW'($urandom);
                s_a[k]   = (k == 0) ? 1 : d_a[k-1] + 1;
                d_a[k]   = s_a[k] + ((dly_a[k] >= TO) ? TO : dly_a[k] + 1);
            end
            dm_we    = has_dm ? we_a[dm_idx] : 1'b0;
            dm_addr  = has_dm ? addr_a[dm_idx] : '0;
            dm_wdata = has_dm ? wd_a[dm_idx] : '0;
            if_addr  = has_if ? addr_a[if_idx] : '0;
            repeat ($urandom_range(0, 2)) step();
            step();
            for (int t = 0; t <= d_a[n-1] + 1; t++) begin
                bit exp_ifd = has_if && (t == d_a[if_idx]);
                bit exp_dmd = has_dm && (t == d_a[dm_idx]);
                int ek = -1;
                if (t > 0) begin
                    step();
                    for (int k = 0; k < n; k++) begin
                        if (t >= s_a[k] && t < d_a[k]) ek = k;
                    end
                    if (exp_ifd) begin
                        exp_if_rd = (dly_a[if_idx] >= TO) ? '0 : rd_a[if_idx];
                        if (dly_a[if_idx] >= TO) exp_err = 1'b1;
                    end
                    if (exp_dmd) begin
                        exp_dm_rd = (dly_a[dm_idx] >= TO || we_a[dm_idx]) ? '0 : rd_a[dm_idx];
                        if (dly_a[dm_idx] >= TO) exp_err = 1'b1;
                    end
                    checks++;
                    if (mem_en !== (ek >= 0)) begin
                        errors++;
                        $display("FAIL rand_mem_en it=%0d t=%0d: got %b expected %b", it, t, mem_en, ek >= 0);
                    end
                    if (ek >= 0) begin
                        checks++;
                        if ({mem_we, mem_addr} !== {we_a[ek], addr_a[ek]}) begin
                            errors++;
                            $display("FAIL rand_port it=%0d t=%0d: got we %b addr %h expected %b %h", it, t, mem_we, mem_addr, we_a[ek], addr_a[ek]);
                        end
                        if (we_a[ek]) begin
                            checks++;
                            if (mem_wdata !== wd_a[ek]) begin
                                errors++;
                                $display("FAIL rand_wdata it=%0d t=%0d: got %h expected %h", it, t, mem_wdata, wd_a[ek]);
                            end
                        end
                    end
                    checks++;
                    if ({if_done, dm_done, err} !== {exp_ifd, exp_dmd, exp_err}) begin
                        errors++;
                        $display("FAIL rand_flags it=%0d t=%0d: got ifd/dmd/err %b expected %b", it, t, {if_done, dm_done, err}, {exp_ifd, exp_dmd, exp_err});
                    end
                    checks++;
                    if ({if_rdata, dm_rdata} !== {exp_if_rd, exp_dm_rd}) begin
                        errors++;
                        $display("FAIL rand_rdata it=%0d t=%0d: got %h %h expected %h %h", it, t, if_rdata, dm_rdata, exp_if_rd, exp_dm_rd);
                    end
                end
                if_req    = has_if && (t <= d_a[if_idx]);
                dm_req    = has_dm && (t <= d_a[dm_idx]);
                mem_ready = 1'b0;
                mem_rdata = DW'($urandom);
                for (int k = 0; k < n; k++) begin
                    if (dly_a[k] < TO && t == s_a[k] + dly_a[k]) begin
                        mem_ready = 1'b1;
                        mem_rdata = rd_a[k];
                    end
                end
                #1;
                checks++;
                if (stall !== ((if_req && !exp_ifd) || (dm_req && !exp_dmd))) begin
                    errors++;
                    $display("FAIL rand_stall it=%0d t=%0d: got %b", it, t, stall);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_timeout();
        test_reset_mid();
        test_held();
        test_random(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
